cyclic_prefix_insert: RTL
=========================

# cyclic_prefix_insert

Transmit-side counterpart of the cyclic-prefix removal kernel: accepts OFDM time-domain symbols of N complex samples on a valid/ready stream and emits each symbol with its last CP_LEN samples prepended (N+CP_LEN output samples per symbol). Sits between the IFFT output and the DAC/framing stage. A ping-pong buffer lets one symbol be written while the previous one is read out, for full throughput.

## Interface
- DATA_W, 32: sample width (16-bit I, 16-bit Q packed {I,Q})
- N, 64: symbol length in samples; power of two, 16..4096
- CP_LEN, 16: prefix length; 1 <= CP_LEN < N
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  input can accept
- s_data  in  DATA_W  input sample
- s_last  in  1  marks sample N-1 of a symbol (checked, not used for framing)
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream can accept
- m_data  out  DATA_W  output sample
- m_last  out  1  final sample of an output symbol
- frame_err  out  1  one-cycle pulse on s_last misalignment

## Operation
- Two banks of N words. Write side fills wr_bank at addresses 0..N-1 (wr_cnt). On accepting sample N-1: mark bank full, toggle wr_bank, wr_cnt wraps to 0.
- s_ready = 1 while wr_bank is not full. Both banks full -> s_ready = 0.
- Read FSM: IDLE -> CP when rd_bank full. CP reads addresses N-CP_LEN..N-1; BODY reads 0..N-1. After last BODY read is accepted: clear rd_bank full, toggle rd_bank, go to CP if the other bank is full, else IDLE.
- m_last = 1 only with body address N-1. m_data for CP sample k equals input sample N-CP_LEN+k.
- frame_err pulses the cycle after an accepted sample where s_last != (wr_cnt == N-1). Framing always follows wr_cnt; data is not dropped.
- A bank freed and a bank filled in the same cycle are both honoured; s_ready does not drop.
- Reset: both banks empty, wr_bank = rd_bank = 0, counters 0, FSM IDLE. Partial symbols are discarded. Reset outputs: s_ready = 0 during reset, 1 from the first cycle after; m_valid = 0, m_last = 0, frame_err = 0, m_data = 0.

## Timing
- RAM read latency is 1 cycle. The output stage is a 2-entry skid register, so m_ready does not combinationally reach the RAM address.
- First m_valid asserts on the 2nd rising edge after the edge accepting sample N-1, when the read side was IDLE.
- With m_ready held high, output is gapless: N+CP_LEN consecutive m_valid cycles per symbol, and back-to-back symbols have no bubble.
- m_ready low: m_valid/m_data/m_last hold stable; no sample is lost or duplicated.
- Sustained input at 1 sample/cycle with m_ready = 1 backpressures periodically: s_ready duty is N/(N+CP_LEN).

## Structure
- Package cp_pkg: default N/CP_LEN/DATA_W, rd_state_t enum {IDLE, CP, BODY}, ADDR_W = $clog2(N).
- Sub-module cp_pingpong_ram: 2 x N x DATA_W simple dual-port RAM, one write port and one registered read port, with bank-select address bit as MSB.
- Top holds the write counter, bank-full flags, read FSM and skid register.

## Test plan
- Single symbol, data = index 0..63, m_ready = 1: output 48..63 then 0..63. m_last only on the final 63. First m_valid 2 cycles after input 63.
- Four back-to-back symbols, s_valid = 1 and m_ready = 1 throughout: 320 contiguous output beats. s_ready low 16 of every 80 cycles in steady state.
- Random m_ready (50%) with random s_valid: scoreboard matches the expected CP+body sequence, and m_data holds while stalled.
- s_last asserted at sample 30: frame_err pulse one cycle after. Output still 80 samples framed on a 64-sample boundary.
- Both banks full, m_ready = 0: s_ready = 0. Release m_ready: s_ready rises the cycle after the first bank's m_last beat is accepted.
- Reset asserted mid-BODY at address 20: the next cycle has m_valid = 0. A fresh symbol after reset emits its correct 80 samples with no residue.

Source files
------------

// File: rtl/cp_pkg.sv
// rtl/cp_pkg.sv - shared defaults and read-state encoding for the cyclic prefix inserter
package cp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_N      = 64;
  localparam int DEF_CP_LEN = 16;
  localparam int ADDR_W     = $clog2(DEF_N);

  typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_t;
endpackage

// File: rtl/cp_pingpong_ram.sv
// rtl/cp_pingpong_ram.sv - two-bank symbol store, bank select is the address MSB
module cp_pingpong_ram
  import cp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW:0]       waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW:0]       raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**(AW+1)];

  // rdata holds between reads; the top relies on it as a storage slot
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cyclic_prefix_insert.sv
// rtl/cyclic_prefix_insert.sv - prepends the last CP_LEN samples of each N-sample symbol
module cyclic_prefix_insert
  import cp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  parameter int CP_LEN = DEF_CP_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              frame_err
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [AW-1:0] CP_START  = AW'(N - CP_LEN);

  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic [1:0]    full;
  logic          wr_fire, wr_end;

  rd_state_t     state, state_nx;
  logic          rd_bank, rd_bank_nx;
  logic [AW-1:0] rd_addr, rd_addr_nx, cur_addr;
  logic          issue, issue_last;

  logic              dv, dv_last;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] sk_data0, sk_data1;
  logic              sk_last0, sk_last1;
  logic [1:0]        sk_cnt;
  logic              xfer, can_issue, pop, out_bank;
  logic [1:0]        set_mask, clr_mask;

  assign s_ready = !reset && !full[wr_bank];
  assign wr_fire = s_valid && s_ready;
  assign wr_end  = wr_fire && (wr_cnt == LAST_ADDR);

  // Read issue never looks at m_ready: the RAM output register plus the two
  // skid entries give three slots, enough to cover the issue-to-pop loop.
  assign xfer      = dv && (sk_cnt != 2'd2);
  assign can_issue = !dv || xfer;
  assign m_valid   = (sk_cnt != 2'd0);
  assign m_data    = sk_data0;
  assign m_last    = m_valid && sk_last0;
  assign pop       = m_valid && m_ready;

  // A bank is released only once its final beat has left the block
  assign set_mask = wr_end ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = (pop && sk_last0) ? (out_bank ? 2'b10 : 2'b01) : 2'b00;

  cp_pingpong_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clock (clock),
    .we    (wr_fire),
    .waddr ({wr_bank, wr_cnt}),
    .wdata (s_data),
    .re    (issue),
    .raddr ({rd_bank, cur_addr}),
    .rdata (rdata)
  );

  always_comb begin
    state_nx   = state;
    rd_addr_nx = rd_addr;
    rd_bank_nx = rd_bank;
    issue      = 1'b0;
    issue_last = 1'b0;
    cur_addr   = (state == IDLE) ? CP_START : rd_addr;
    case (state)
      IDLE, CP: begin
        if ((state == CP || full[rd_bank]) && can_issue) begin
          issue = 1'b1;
          if (cur_addr == LAST_ADDR) begin
            state_nx   = BODY;
            rd_addr_nx = '0;
          end else begin
            state_nx   = CP;
            rd_addr_nx = cur_addr + AW'(1);
          end
        end
      end
      BODY: begin
        if (can_issue) begin
          issue = 1'b1;
          if (rd_addr == LAST_ADDR) begin
            issue_last = 1'b1;
            rd_bank_nx = !rd_bank;
            if (full[!rd_bank]) begin
              state_nx   = CP;
              rd_addr_nx = CP_START;
            end else begin
              state_nx   = IDLE;
              rd_addr_nx = '0;
            end
          end else begin
            rd_addr_nx = rd_addr + AW'(1);
          end
        end
      end
      default: begin
        state_nx   = IDLE;
        rd_addr_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      full      <= 2'b00;
      frame_err <= 1'b0;
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      dv        <= 1'b0;
      dv_last   <= 1'b0;
      sk_cnt    <= 2'd0;
      sk_data0  <= '0;
      sk_data1  <= '0;
      sk_last0  <= 1'b0;
      sk_last1  <= 1'b0;
      out_bank  <= 1'b0;
    end else begin
      if (wr_fire) wr_cnt <= wr_cnt + AW'(1);
      if (wr_end)  wr_bank <= !wr_bank;
      full      <= (full | set_mask) & ~clr_mask;
      frame_err <= wr_fire && (s_last != (wr_cnt == LAST_ADDR));

      state   <= state_nx;
      rd_bank <= rd_bank_nx;
      rd_addr <= rd_addr_nx;

      if (issue) begin
        dv      <= 1'b1;
        dv_last <= issue_last;
      end else if (xfer) begin
        dv <= 1'b0;
      end

      if (pop && sk_last0) out_bank <= !out_bank;

      // xfer with pop can only happen at sk_cnt == 1
      case ({xfer, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) begin
            sk_data0 <= rdata;
            sk_last0 <= dv_last;
          end else begin
            sk_data1 <= rdata;
            sk_last1 <= dv_last;
          end
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk_data0 <= sk_data1;
          sk_last0 <= sk_last1;
          sk_cnt   <= sk_cnt - 2'd1;
        end
        2'b11: begin
          sk_data0 <= rdata;
          sk_last0 <= dv_last;
        end
        default: ;
      endcase
    end
  end

endmodule
